// File: rtl/gf180mcu_cell_bist2.sv
// Exhaustive A1/A2 sweep driver and ZN checker for two-input cells: NOR golden compare plus MISR signature.
// Run takes 4*NUM_PASSES*SETTLE cycles from START to DONE; no backpressure, START is ignored while a run is active.
module gf180mcu_cell_bist2 #(
  parameter int unsigned       NUM_PASSES = 4,
  parameter int unsigned       SETTLE     = 2,
  parameter int unsigned       SIG_W      = 16,
  parameter logic [SIG_W-1:0]  POLY       = 16'h1021,
  parameter logic [SIG_W-1:0]  EXP_SIG    = 16'h8888
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [7:0]       ERR_CNT,
  output logic [SIG_W-1:0] SIG
);

  localparam int unsigned    SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]  S_LAST = SW'(SETTLE - 1);
  localparam logic [7:0]     P_LAST = 8'(NUM_PASSES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       v_q, v_d;
  logic [7:0]       p_q, p_d;
  logic [SW-1:0]    s_q, s_d;
  logic             a1_q, a1_d, a2_q, a2_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] misr;
  logic             mismatch;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      v_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      a1_q    <= 1'b0;
      a2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      p_q     <= p_d;
      s_q     <= s_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      sig_q   <= sig_d;
    end
  end

  // The golden compare uses the vector currently on the cell pins, not v_q's next value.
  assign misr     = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-1){1'b0}}, ZN};
  assign mismatch = (ZN != ~(a1_q | a2_q));

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    p_d     = p_q;
    s_d     = s_q;
    pass_d  = pass_q;
    err_d   = err_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = DRIVE;
          sig_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          v_d     = '0;
          p_d     = '0;
          s_d     = '0;
        end
      end
      DRIVE: begin
        if (s_q == S_LAST) begin
          sig_d = misr;
          if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
          s_d = '0;
          v_d = v_q + 2'd1;
          if (v_q == 2'd3) begin
            p_d = p_q + 8'd1;
            if (p_q == P_LAST) begin
              state_d = FIN;
              pass_d  = (err_d == 8'd0) && (sig_d == EXP_SIG);
            end
          end
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    a1_d   = (state_d == DRIVE) & v_d[0];
    a2_d   = (state_d == DRIVE) & v_d[1];
    busy_d = (state_d == DRIVE);
    done_d = (state_d == FIN);
  end

  assign A1      = a1_q;
  assign A2      = a2_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = err_q;
  assign SIG     = sig_q;

endmodule

// File: tb/tb_gf180mcu_cell_bist2.sv
// Scoreboard bench: cell behaviour is a 4-entry truth table indexed by {A2,A1}; results come from a truth-table model.
module tb_gf180mcu_cell_bist2;

  typedef struct packed {
    logic [7:0]  err;
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn0 = 1'b1, start0 = 1'b0, zn0;
  logic        a1_0, a2_0, busy0, done0, pass0;
  logic [7:0]  err0;
  logic [15:0] sig0;
  logic [3:0]  tt0 = 4'b0001;

  logic        rn1 = 1'b1, start1 = 1'b0, zn1;
  logic        a1_1, a2_1, busy1, done1, pass1;
  logic [7:0]  err1;
  logic [15:0] sig1;

  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] vq[$];

  assign zn0 = tt0[{a2_0, a1_0}];
  assign zn1 = 1'b1;

  gf180mcu_cell_bist2 dut0 (
    .CLK(clk), .RN(rn0), .START(start0), .ZN(zn0), .A1(a1_0), .A2(a2_0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .SIG(sig0)
  );

  gf180mcu_cell_bist2 #(.NUM_PASSES(100), .SETTLE(1)) dut1 (
    .CLK(clk), .RN(rn1), .START(start1), .ZN(zn1), .A1(a1_1), .A2(a2_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1), .SIG(sig1)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: event seen 1, expected 0", n);
  endtask

  function automatic exp_t mk(input int e, input logic [15:0] s, input logic p, input int c);
    exp_t r;
    r.err = 8'(e); r.sig = s; r.pass = p; r.cyc = 16'(c);
    return r;
  endfunction

  // A NOR cell outputs 1 only for vector 00; every sample shifts its ZN into the signature.
  function automatic exp_t model(input logic [3:0] tt, input int passes, input int settle);
    int          e = 0;
    logic [15:0] s = '0;
    logic        b;
    for (int p = 0; p < passes; p++)
      for (int v = 0; v < 4; v++) begin
        b = tt[v];
        if (b != (v == 0)) e++;
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'b0, b};
      end
    return mk((e > 255) ? 255 : e, s, (e == 0) && (s == 16'h8888), 4 * passes * settle);
  endfunction

  task automatic push_vecs0();
    for (int p = 0; p < 4; p++)
      for (int v = 0; v < 4; v++)
        for (int s = 0; s < 2; s++) vq.push_back(2'(v));
  endtask

  task automatic wait_for(input int which, input int limit, input string n);
    int k = 0;
    while (k < limit) begin
      if ((which == 0 && done0) || (which == 1 && busy0) || (which == 2 && done1)) break;
      @(negedge clk);
      k++;
    end
    if (k >= limit) chk(n, 32'd0, 32'd1);
  endtask

  task automatic run0(input logic [3:0] tt, input exp_t e);
    tt0 = tt;
    q0.push_back(e);
    push_vecs0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait_for(0, 200, "done_timeout");
    @(negedge clk);
  endtask

  task automatic chk_zero0(input string n);
    chk({n, "_a1"}, a1_0, 0);
    chk({n, "_a2"}, a2_0, 0);
    chk({n, "_busy"}, busy0, 0);
    chk({n, "_done"}, done0, 0);
    chk({n, "_pass"}, pass0, 0);
    chk({n, "_err"}, err0, 0);
    chk({n, "_sig"}, sig0, 0);
  endtask

  // Monitor for the default-parameter instance.
  initial begin
    int   bcnt = 0;
    logic pb = 1'b0, pd = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rn0) begin
        bcnt = 0; pb = 1'b0; pd = 1'b0;
      end else begin
        if (pd) chk("done_width", done0, 0);
        if (busy0 && !pb) begin
          chk("start_clr_sig", sig0, 0);
          chk("start_clr_err", err0, 0);
          chk("start_clr_pass", pass0, 0);
        end
        if (busy0) begin
          bcnt++;
          if (vq.size() == 0) fail("extra_vector");
          else chk("vector", {a2_0, a1_0}, vq.pop_front());
        end
        if (done0) begin
          if (q0.size() == 0) fail("unexpected_done");
          else begin
            e = q0.pop_front();
            chk("err_cnt", err0, e.err);
            chk("sig", sig0, e.sig);
            chk("pass", pass0, e.pass);
            chk("busy_cycles", bcnt, e.cyc);
            chk("busy_at_done", busy0, 0);
          end
          bcnt = 0;
        end
        pb = busy0; pd = done0;
      end
    end
  end

  // Monitor for the 100-pass, single-cycle-settle instance.
  initial begin
    int   bcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy1) bcnt++;
      if (done1) begin
        if (q1.size() == 0) fail("unexpected_done1");
        else begin
          e = q1.pop_front();
          chk("sat_err_cnt", err1, e.err);
          chk("sat_sig", sig1, e.sig);
          chk("sat_pass", pass1, e.pass);
          chk("sat_busy_cycles", bcnt, e.cyc);
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    logic [3:0] tt;
    #1 rn0 = 1'b0; rn1 = 1'b0;
    #1 chk_zero0("reset");
    @(negedge clk) rn0 = 1'b1; rn1 = 1'b1;
    @(negedge clk);

    run0(4'b0001, mk(0, 16'h8888, 1'b1, 32));
    run0(4'b0000, mk(4, 16'h0000, 1'b0, 32));
    run0(4'b1111, mk(12, 16'hFFFF, 1'b0, 32));
    repeat (6) begin
      tt = 4'($urandom_range(0, 15));
      run0(tt, model(tt, 4, 2));
    end

    // Reset ten cycles into a run: everything clears at once and no DONE follows.
    tt0 = 4'b0001;
    q0.push_back(mk(0, 16'h8888, 1'b1, 32));
    push_vecs0();
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    start0 = 1'b0;
    repeat (10) @(posedge clk);
    #2 rn0 = 1'b0;
    #1 chk_zero0("midrun_reset");
    q0.delete();
    vq.delete();
    @(negedge clk) rn0 = 1'b1;
    repeat (40) @(negedge clk);
    run0(4'b0001, mk(0, 16'h8888, 1'b1, 32));

    // START held high across two runs.
    tt0 = 4'b0001;
    q0.push_back(mk(0, 16'h8888, 1'b1, 32));
    q0.push_back(mk(0, 16'h8888, 1'b1, 32));
    push_vecs0();
    push_vecs0();
    @(negedge clk) start0 = 1'b1;
    wait_for(1, 5, "held_busy1_timeout");
    wait_for(0, 200, "held_done1_timeout");
    @(negedge clk);
    wait_for(1, 5, "held_restart_timeout");
    start0 = 1'b0;
    wait_for(0, 200, "held_done2_timeout");
    @(negedge clk);
    chk("held_vectors_left", vq.size(), 0);

    q1.push_back(model(4'b1111, 100, 1));
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_for(2, 1000, "sat_done_timeout");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
